qpmm_d0_16_16: RTL and testbench



---
 rtl/qpmm_d0_16_16_pkg.sv | 42 ++++
 rtl/qpmm_d0_16_16_row.sv | 64 ++++++
 rtl/qpmm_d0_16_16.sv | 82 ++++++++
 tb/tb_qpmm_d0_16_16.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/qpmm_d0_16_16_pkg.sv
// BN254 base-field constants and types for the 16/16-digit, d=0 QPMM core.
// The Montgomery constants are derived from the modulus at elaboration time.
package PARAMS_BN254_16_16;

    localparam int DIGIT_W  = 16;
    localparam int NUM_ITER = 18;
    localparam int FP_W     = 272;
    // S stays below 2^273 between rows; the row-internal sum stays below 2^290.
    localparam int S_W      = 274;
    localparam int T_W      = 290;
    localparam int LATENCY  = 58;

    typedef logic [FP_W-1:0] qpmm_fp_t;

    localparam logic [255:0] MOD_256 =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam logic [253:0] Mod = MOD_256[253:0];

    // Newton iteration for p^-1 mod 2^16; each step doubles the correct bits.
    function automatic logic [DIGIT_W-1:0] calc_m_prime(input logic [DIGIT_W-1:0] p_lo);
        logic [DIGIT_W-1:0] inv;
        inv = p_lo;
        for (int i = 0; i < 4; i++) begin
            inv = inv * (16'd2 - p_lo * inv);
        end
        return 16'd0 - inv;
    endfunction

    // 2^-288 mod p by repeated modular halving.
    function automatic logic [253:0] calc_r_inv(input logic [253:0] p);
        logic [254:0] x;
        x = 255'd1;
        for (int i = 0; i < NUM_ITER * DIGIT_W; i++) begin
            x = x[0] ? ((x + {1'b0, p}) >> 1) : (x >> 1);
        end
        return x[253:0];
    endfunction

    localparam logic [DIGIT_W-1:0] M_PRIME = calc_m_prime(Mod[DIGIT_W-1:0]);
    localparam logic [253:0]       R_INV   = calc_r_inv(Mod);

endpackage

// File: rtl/qpmm_d0_16_16_row.sv
// One Montgomery iteration: S += A*b, q = S*M' mod 2^16, S = (S + q*p) >> 16.
// Latency 3 cycles; no backpressure, a new operand set is accepted every cycle.
module qpmm_row
    import PARAMS_BN254_16_16::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  qpmm_fp_t       a_i,
    input  qpmm_fp_t       b_i,
    input  logic [S_W-1:0] s_i,
    output qpmm_fp_t       a_o,
    output qpmm_fp_t       b_o,
    output logic [S_W-1:0] s_o
);

    logic [T_W-1:0]     t1_d, t1_q, t2_q, u;
    logic [DIGIT_W-1:0] q_d, q_q;
    logic [S_W-1:0]     s_d, s_q;
    qpmm_fp_t           a1_q, a2_q, a3_q;
    qpmm_fp_t           b1_q, b2_q, b3_q;
    logic               unused_lo;

    always_comb begin
        t1_d = T_W'(s_i) + T_W'(a_i) * T_W'(b_i[DIGIT_W-1:0]);
        q_d  = t1_q[DIGIT_W-1:0] * M_PRIME;
        u    = t2_q + T_W'(q_q) * T_W'(Mod);
        s_d  = u[T_W-1:DIGIT_W];
    end

    // Low digit of u is zero by construction of q.
    assign unused_lo = ^u[DIGIT_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t1_q <= '0;
            t2_q <= '0;
            q_q  <= '0;
            s_q  <= '0;
            a1_q <= '0;
            a2_q <= '0;
            a3_q <= '0;
            b1_q <= '0;
            b2_q <= '0;
            b3_q <= '0;
        end else begin
            t1_q <= t1_d;
            t2_q <= t1_q;
            q_q  <= q_d;
            s_q  <= s_d;
            a1_q <= a_i;
            a2_q <= a1_q;
            a3_q <= a2_q;
            // The consumed digit is dropped so the next row sees its own digit at [15:0].
            b1_q <= b_i >> DIGIT_W;
            b2_q <= b1_q;
            b3_q <= b2_q;
        end
    end

    assign a_o = a3_q;
    assign b_o = b3_q;
    assign s_o = s_q;

endmodule

// File: rtl/qpmm_d0_16_16.sv
// Pipelined BN254 Montgomery multiplier, Z = A*B*2^-288 (redundant); optional QPMM_VALID_EN sideband.
// Latency 58 cycles (input reg, 18 rows x 3, 3 output regs); no backpressure, one pair per cycle.
module qpmm_d0_16_16
    import PARAMS_BN254_16_16::*;
(
    input  logic     clk,
    input  logic     rstn,
`ifdef QPMM_VALID_EN
    input  logic     in_valid,
    output logic     out_valid,
`endif
    input  qpmm_fp_t A,
    input  qpmm_fp_t B,
    output qpmm_fp_t Z
);

    qpmm_fp_t       a_q, b_q;
    qpmm_fp_t       z1_q, z2_q, z3_q;
    qpmm_fp_t       a_c [0:NUM_ITER];
    qpmm_fp_t       b_c [0:NUM_ITER];
    logic [S_W-1:0] s_c [0:NUM_ITER];
    logic           unused_tail;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    assign a_c[0] = a_q;
    assign b_c[0] = b_q;
    assign s_c[0] = '0;

    for (genvar i = 0; i < NUM_ITER; i++) begin : g_row
        qpmm_row u_row (
            .clk  (clk),
            .rstn (rstn),
            .a_i  (a_c[i]),
            .b_i  (b_c[i]),
            .s_i  (s_c[i]),
            .a_o  (a_c[i+1]),
            .b_o  (b_c[i+1]),
            .s_o  (s_c[i+1])
        );
    end

    // Final S < 2^257, so the top bits of the last row and its operand copies carry nothing.
    assign unused_tail = ^{a_c[NUM_ITER], b_c[NUM_ITER], s_c[NUM_ITER][S_W-1:FP_W]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            z1_q <= '0;
            z2_q <= '0;
            z3_q <= '0;
        end else begin
            z1_q <= s_c[NUM_ITER][FP_W-1:0];
            z2_q <= z1_q;
            z3_q <= z2_q;
        end
    end

    assign Z = z3_q;

`ifdef QPMM_VALID_EN
    logic [LATENCY-1:0] vld_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = vld_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_qpmm_d0_16_16.sv
// Scoreboarded bench for qpmm_d0_16_16: bulk Montgomery reference (Q = -AB/p mod 2^288),
// congruence checks on directed vectors, reset behaviour and a long random stream.
module tb_qpmm_d0_16_16;

    localparam int LAT = 58;
    localparam logic [575:0] P576 =
        576'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic         clk;
    logic         rstn;
    logic [271:0] A, B, Z;
`ifdef QPMM_VALID_EN
    logic         in_valid, out_valid;
`endif

    typedef struct {
        logic [271:0] exp;
        logic [271:0] a;
        logic [271:0] b;
        int           kind;   // 0 bit-exact only, 1 plus congruence, 2 plus Montgomery-one
        bit           v;
    } sb_t;

    sb_t          sb[$];
    int           n_chk;
    int           n_fail;
    logic [287:0] pinv;
    logic [575:0] rm576;

    qpmm_d0_16_16 dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef QPMM_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .A         (A),
        .B         (B),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [271:0] rnd272();
        logic [271:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[239:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [271:0] modp(input logic [575:0] x);
        logic [575:0] r;
        r = x % P576;
        return r[271:0];
    endfunction

    // Z*2^288 = A*B + Q*p with Q the unique value below 2^288 clearing the low 288 bits.
    function automatic logic [271:0] mont_ref(input logic [271:0] a, input logic [271:0] b);
        logic [575:0] ab, q, t;
        ab = 576'(a) * 576'(b);
        q  = 576'd0 - ab;
        q  = 576'(q[287:0]) * 576'(pinv);
        q  = 576'(q[287:0]);
        t  = ab + q * P576;
        return t[559:288];
    endfunction

    task automatic pop_check();
        sb_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("z", Z, e.exp);
`ifdef QPMM_VALID_EN
            chk("out_valid", 272'(out_valid), 272'(e.v));
`endif
            if (e.kind != 0) begin
                chk("z_below_2^257", 272'(Z[271:257]), 272'd0);
                chk("congr", modp(576'(Z) * rm576), modp(576'(e.a) * 576'(e.b)));
            end
            if (e.kind == 2) chk("mont_one", modp(576'(Z)), modp(576'(e.b)));
        end
    endtask

    task automatic drive(input logic [271:0] a, input logic [271:0] b, input int kind, input bit v);
        sb_t e;
        @(negedge clk);
        pop_check();
        A = a;
        B = b;
`ifdef QPMM_VALID_EN
        in_valid = v;
`endif
        e.exp  = mont_ref(a, b);
        e.a    = a;
        e.b    = b;
        e.kind = kind;
        e.v    = v;
        sb.push_back(e);
    endtask

    // Called at a negedge: the pipeline is all zero, so the next LAT samples of Z are zero.
    task automatic release_reset();
        sb_t e;
        rstn = 1'b1;
        A = '0;
        B = '0;
        sb.delete();
        e.exp = '0; e.a = '0; e.b = '0; e.kind = 0; e.v = 1'b0;
        for (int i = 0; i < LAT; i++) sb.push_back(e);
    endtask

    initial begin
        logic [271:0] rm, ones, x;
        bit           abort;
        n_chk  = 0;
        n_fail = 0;
        abort  = 1'b0;
        rstn   = 1'b0;
        A      = '0;
        B      = '0;
`ifdef QPMM_VALID_EN
        in_valid = 1'b0;
`endif
        pinv = P576[287:0];
        for (int i = 0; i < 7; i++) pinv = pinv * (288'd2 - P576[287:0] * pinv);
        rm576 = (576'd1 << 288) % P576;
        rm    = rm576[271:0];
        ones  = '1;

        #1 chk("reset_z", Z, 272'd0);
`ifdef QPMM_VALID_EN
        chk("reset_out_valid", 272'(out_valid), 272'd0);
`endif
        repeat (2) @(negedge clk);
        release_reset();

        // Directed vectors.
        drive('0, rnd272(), 0, 1'b0);
        drive('0, ones, 0, 1'b0);
        drive(rm, rnd272(), 2, 1'b1);
        drive(rm, 272'd1, 2, 1'b0);
        drive(rm, 272'(P576 - 576'd1), 2, 1'b0);
        drive(ones, ones, 1, 1'b0);
        drive(ones, rnd272(), 1, 1'b0);
        drive(rnd272(), ones, 1, 1'b0);
        for (int i = 0; i < 6; i++) drive(rnd272(), rnd272(), 1, 1'b0);
        repeat (LAT) drive('0, '0, 0, 1'b0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 20; i++) drive(rnd272(), rnd272(), 0, 1'b1);
        #2 rstn = 1'b0;
        A = '0;
        B = '0;
`ifdef QPMM_VALID_EN
        in_valid = 1'b0;
`endif
        #1 chk("reset_async_z", Z, 272'd0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_z", Z, 272'd0);
`ifdef QPMM_VALID_EN
            chk("reset_hold_valid", 272'(out_valid), 272'd0);
`endif
        end
        release_reset();
        for (int i = 0; i < 10; i++) drive(rnd272(), rnd272(), 1, 1'b0);

        // Long back-to-back random stream; stop at the first mismatch.
        for (int i = 0; i < 10000; i++) begin
            x = rnd272();
            drive(x, rnd272(), 0, x[0]);
            if (n_fail != 0) begin
                abort = 1'b1;
                break;
            end
        end
        if (!abort) repeat (LAT) drive('0, '0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
